jk_excitation_driver: RTL and testbench

Sequential driver for a bank of WIDTH JK flip-flops: the producer side of the J/K interface. Accepts a target state word over a valid/ready handshake and computes the J/K excitation from the bank's current Q. It issues a one-cycle clock-enable strobe to the bank, waits a settle interval, and checks that the bank's Q reached the target. It sits between a test/sequence source and any JK-flip-flop-based register, counter or state machine in the design.

---
 rtl/jk_excitation_driver.sv | 134 +++++++++++++
 tb/tb_jk_excitation_driver.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Producer side of a JK flip-flop bank: drives J/K excitation for a target
// word, strobes the bank, waits a settle interval and checks the result.
module jk_excitation_driver #(
    parameter int WIDTH       = 4,
    parameter int SETTLE      = 1,
    parameter int TOGGLE_MODE = 0
) (
    input  logic             input_clock,
    input  logic             input_reset,
    input  logic             input_target_valid,
    output logic             output_target_ready,
    input  logic [WIDTH-1:0] input_target_data,
    input  logic [WIDTH-1:0] input_q,
    output logic [WIDTH-1:0] output_j,
    output logic [WIDTH-1:0] output_k,
    output logic             output_ff_enable,
    output logic             output_done,
    output logic             output_mismatch,
    output logic [WIDTH-1:0] output_mismatch_mask,
    output logic [7:0]       output_error_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [7:0]       err_q, err_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] chk;

    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            mask_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= en_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    // Excitation is computed at the accept edge so J/K/enable are
    // registered and present for exactly the DRIVE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        j_d     = '0;
        k_d     = '0;
        en_d    = 1'b0;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        mask_d  = mask_q;
        err_d   = err_q;
        diff    = input_target_data ^ input_q;
        chk     = input_q ^ t_q;
        unique case (state_q)
            S_IDLE: begin
                if (input_target_valid) begin
                    t_d  = input_target_data;
                    en_d = 1'b1;
                    if (TOGGLE_MODE != 0) begin
                        j_d = diff;
                        k_d = diff;
                    end else begin
                        j_d = diff & input_target_data;
                        k_d = diff & ~input_target_data;
                    end
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d   = 4'(SETTLE - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                done_d = 1'b1;
                mask_d = chk;
                if (|chk) begin
                    mis_d = 1'b1;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign output_target_ready  = (state_q == S_IDLE);
    assign output_j             = j_q;
    assign output_k             = k_q;
    assign output_ff_enable     = en_q;
    assign output_done          = done_q;
    assign output_mismatch      = mis_q;
    assign output_mismatch_mask = mask_q;
    assign output_error_count   = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: JK bank models, scoreboard of expected
// check results, two instances (set/reset SETTLE=1, toggle SETTLE=3).
module tb_jk_excitation_driver;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] mask;
        logic       mis;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       vld[2];
    logic [3:0] dd[2];
    logic       rdy[2];
    logic [3:0] qm[2];
    logic [3:0] jo[2];
    logic [3:0] ko[2];
    logic       en[2];
    logic       done[2];
    logic       mis[2];
    logic [3:0] mmask[2];
    logic [7:0] err[2];
    bit         stuck[2];
    bit         frc[2];
    logic [3:0] fval[2];

    exp_t sb[$];
    int total;
    int bad;

    jk_excitation_driver #(.WIDTH(4), .SETTLE(1), .TOGGLE_MODE(0)) u_a (
        .input_clock(clk),
        .input_reset(rst),
        .input_target_valid(vld[0]),
        .output_target_ready(rdy[0]),
        .input_target_data(dd[0]),
        .input_q(qm[0]),
        .output_j(jo[0]),
        .output_k(ko[0]),
        .output_ff_enable(en[0]),
        .output_done(done[0]),
        .output_mismatch(mis[0]),
        .output_mismatch_mask(mmask[0]),
        .output_error_count(err[0])
    );

    jk_excitation_driver #(.WIDTH(4), .SETTLE(3), .TOGGLE_MODE(1)) u_b (
        .input_clock(clk),
        .input_reset(rst),
        .input_target_valid(vld[1]),
        .output_target_ready(rdy[1]),
        .input_target_data(dd[1]),
        .input_q(qm[1]),
        .output_j(jo[1]),
        .output_k(ko[1]),
        .output_ff_enable(en[1]),
        .output_done(done[1]),
        .output_mismatch(mis[1]),
        .output_mismatch_mask(mmask[1]),
        .output_error_count(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // JK bank models: Q+ = J&~Q | ~K&Q on enabled edges
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (frc[i]) qm[i] <= fval[i];
            else if (en[i] && !stuck[i]) qm[i] <= (jo[i] & ~qm[i]) | (~ko[i] & qm[i]);
        end
    end

    task automatic set_q(input int s, input logic [3:0] v);
        @(negedge clk);
        frc[s] = 1'b1;
        fval[s] = v;
        @(negedge clk);
        frc[s] = 1'b0;
    endtask

    // called at the DRIVE-cycle negedge; returns cycles since accept
    task automatic wait_done(input int s, output int lat);
        lat = -1;
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            if (done[s]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic accept(input int s, input logic [3:0] t);
        @(negedge clk);
        vld[s] = 1'b1;
        dd[s] = t;
        @(negedge clk);
        vld[s] = 1'b0;
    endtask

    task automatic test_reset();
        set_q(0, 4'b0000);
        accept(0, 4'b1111);
        #2 rst = 1'b1;
        #1;
        total++;
        if (en[0] !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", en[0]); end
        total++;
        if (jo[0] !== 4'b0 || ko[0] !== 4'b0) begin
            bad++; $display("FAIL rst_jk got j=%b k=%b want 0000", jo[0], ko[0]);
        end
        total++;
        if (rdy[0] !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", rdy[0]); end
        total++;
        if (done[0] !== 1'b0 || mis[0] !== 1'b0 || mmask[0] !== 4'b0) begin
            bad++; $display("FAIL rst_done got d=%b m=%b mask=%b want 0", done[0], mis[0], mmask[0]);
        end
        total++;
        if (err[0] !== 8'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", err[0]); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_set_excitation();
        int lat;
        exp_t e;
        set_q(0, 4'b0000);
        sb.push_back('{tgt: 4'b1010, mask: 4'b0000, mis: 1'b0});
        accept(0, 4'b1010);
        total++;
        if (jo[0] !== 4'b1010 || ko[0] !== 4'b0000 || en[0] !== 1'b1) begin
            bad++; $display("FAIL set_drive got j=%b k=%b en=%b want 1010 0000 1", jo[0], ko[0], en[0]);
        end
        wait_done(0, lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL set_latency got=%0d want=4", lat); end
        e = sb.pop_front();
        total++;
        if (mis[0] !== e.mis || mmask[0] !== e.mask) begin
            bad++; $display("FAIL set_check got m=%b mask=%b want %b %b", mis[0], mmask[0], e.mis, e.mask);
        end
        total++;
        if (qm[0] !== e.tgt) begin bad++; $display("FAIL set_q got=%b want=%b", qm[0], e.tgt); end
    endtask

    task automatic test_mixed();
        int lat;
        exp_t e;
        set_q(0, 4'b1100);
        sb.push_back('{tgt: 4'b1010, mask: 4'b0000, mis: 1'b0});
        accept(0, 4'b1010);
        total++;
        if (jo[0] !== 4'b0010 || ko[0] !== 4'b0100) begin
            bad++; $display("FAIL mix_sr got j=%b k=%b want 0010 0100", jo[0], ko[0]);
        end
        wait_done(0, lat);
        e = sb.pop_front();
        total++;
        if (lat !== 4 || mis[0] !== e.mis || qm[0] !== e.tgt) begin
            bad++; $display("FAIL mix_sr_done got lat=%0d m=%b q=%b want 4 %b %b", lat, mis[0], qm[0], e.mis, e.tgt);
        end
        set_q(1, 4'b1100);
        sb.push_back('{tgt: 4'b1010, mask: 4'b0000, mis: 1'b0});
        accept(1, 4'b1010);
        total++;
        if (jo[1] !== 4'b0110 || ko[1] !== 4'b0110 || en[1] !== 1'b1) begin
            bad++; $display("FAIL mix_tg got j=%b k=%b en=%b want 0110 0110 1", jo[1], ko[1], en[1]);
        end
        wait_done(1, lat);
        e = sb.pop_front();
        total++;
        if (lat !== 6 || mis[1] !== e.mis || mmask[1] !== e.mask || qm[1] !== e.tgt) begin
            bad++; $display("FAIL mix_tg_done got lat=%0d m=%b q=%b want 6 %b %b", lat, mis[1], qm[1], e.mis, e.tgt);
        end
    endtask

    task automatic test_mismatch();
        int lat;
        int tmo;
        exp_t e;
        set_q(0, 4'b0000);
        stuck[0] = 1'b1;
        sb.push_back('{tgt: 4'b0001, mask: 4'b0001, mis: 1'b1});
        accept(0, 4'b0001);
        wait_done(0, lat);
        e = sb.pop_front();
        total++;
        if (mis[0] !== e.mis || mmask[0] !== e.mask) begin
            bad++; $display("FAIL mis_first got m=%b mask=%b want %b %b", mis[0], mmask[0], e.mis, e.mask);
        end
        total++;
        if (err[0] !== 8'd1) begin bad++; $display("FAIL mis_count1 got=%0d want=1", err[0]); end
        @(negedge clk);
        total++;
        if (done[0] !== 1'b0 || mis[0] !== 1'b0 || mmask[0] !== 4'b0001) begin
            bad++; $display("FAIL mis_pulse got d=%b m=%b mask=%b want 0 0 0001", done[0], mis[0], mmask[0]);
        end
        tmo = 0;
        for (int n = 1; n < 300; n++) begin
            accept(0, 4'b0001);
            wait_done(0, lat);
            if (lat < 0) tmo++;
        end
        total++;
        if (tmo !== 0) begin bad++; $display("FAIL mis_timeout got=%0d want=0", tmo); end
        total++;
        if (err[0] !== 8'd255) begin bad++; $display("FAIL mis_sat got=%0d want=255", err[0]); end
        stuck[0] = 1'b0;
    endtask

    task automatic test_reset_wait();
        int seen_done;
        int seen_en;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (err[0] !== 8'd0) begin bad++; $display("FAIL rw_clear got=%0d want=0", err[0]); end
        set_q(0, 4'b0000);
        stuck[0] = 1'b1;
        accept(0, 4'b0101);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (en[0] !== 1'b0 || jo[0] !== 4'b0 || ko[0] !== 4'b0 || err[0] !== 8'd0) begin
            bad++; $display("FAIL rw_assert got en=%b j=%b k=%b err=%0d want 0", en[0], jo[0], ko[0], err[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        seen_en = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done[0]) seen_done++;
            if (en[0] || jo[0] != 4'b0 || ko[0] != 4'b0) seen_en++;
        end
        total++;
        if (seen_done !== 0 || seen_en !== 0) begin
            bad++; $display("FAIL rw_quiet got done=%0d drive=%0d want 0 0", seen_done, seen_en);
        end
        total++;
        if (rdy[0] !== 1'b1 || err[0] !== 8'd0) begin
            bad++; $display("FAIL rw_after got rdy=%b err=%0d want 1 0", rdy[0], err[0]);
        end
        stuck[0] = 1'b0;
    endtask

    task automatic test_back_to_back(input int s, input int period);
        int acc;
        int last;
        int ndone;
        int bad_gap;
        int bad_res;
        bit acc_prev;
        logic [3:0] dat;
        exp_t e;
        acc = 0;
        last = -1;
        ndone = 0;
        bad_gap = 0;
        bad_res = 0;
        acc_prev = 1'b0;
        dat = 4'h3;
        @(negedge clk);
        vld[s] = 1'b1;
        dd[s] = dat;
        for (int c = 0; c < 100 && ndone < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (acc_prev) begin
                dat = dat + 4'h5;
                dd[s] = dat;
                acc_prev = 1'b0;
                if (acc == 6) vld[s] = 1'b0;
            end
            if (done[s]) begin
                if (sb.size() == 0) begin
                    bad_res++;
                end else begin
                    e = sb.pop_front();
                    if (qm[s] !== e.tgt || mis[s] !== e.mis || mmask[s] !== e.mask) bad_res++;
                end
                ndone++;
            end
            if (vld[s] && rdy[s] && acc < 6) begin
                sb.push_back('{tgt: dat, mask: 4'b0000, mis: 1'b0});
                if (last >= 0 && (c - last) != period) bad_gap++;
                last = c;
                acc++;
                acc_prev = 1'b1;
            end
        end
        vld[s] = 1'b0;
        total++;
        if (ndone !== 6) begin bad++; $display("FAIL b2b_count%0d got=%0d want=6", s, ndone); end
        total++;
        if (bad_gap !== 0) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=0 (period %0d)", s, bad_gap, period); end
        total++;
        if (bad_res !== 0) begin bad++; $display("FAIL b2b_result%0d got=%0d want=0", s, bad_res); end
        sb.delete();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0;
            dd[i] = 4'b0;
            stuck[i] = 1'b0;
            frc[i] = 1'b1;
            fval[i] = 4'b0;
        end
        repeat (3) @(negedge clk);
        total++;
        if (rdy[0] !== 1'b1 || en[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 8'd0) begin
            bad++; $display("FAIL init got rdy=%b en=%b done=%b err=%0d want 1 0 0 0", rdy[0], en[0], done[0], err[0]);
        end
        frc[0] = 1'b0;
        frc[1] = 1'b0;
        rst = 1'b0;
        test_reset();
        test_set_excitation();
        test_mixed();
        test_mismatch();
        test_reset_wait();
        test_back_to_back(0, 4);
        test_back_to_back(1, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
